sram_port_arbiter: RTL
======================

Name: sram_port_arbiter

Overview:
- Shares the single-port 512x8 program/data SRAM between two requesters: the serial loader (SRAM I/O controller) and the 8-bit serial CPU.
- Replaces the static loader/CPU mux with a registered request/grant arbiter.
- Loader has fixed priority, bounded by an anti-starvation counter. A LOCK input gives the loader exclusive ownership during program load.
- Sits between both requesters and the SRAM macro; read data returns with a valid strobe.

Parameters:
- DATA_WIDTH, 8, SRAM word width.
- ADDR_WIDTH, 9, SRAM address width.
- MAX_HOLD, 4, maximum consecutive loader grants while the CPU is waiting (range 1..15).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- LOCK  in  1  loader-exclusive mode; while 1 the CPU is never granted.
- LD_REQ  in  1  loader access request.
- LD_WE  in  1  loader write (1) / read (0).
- LD_A  in  ADDR_WIDTH  loader address.
- LD_D  in  DATA_WIDTH  loader write data.
- LD_GNT  out  1  loader access issued this cycle.
- LD_RVALID  out  1  LD_Q holds read data.
- LD_Q  out  DATA_WIDTH  loader read data.
- CPU_REQ, CPU_WE, CPU_A, CPU_D  in  1/1/ADDR_WIDTH/DATA_WIDTH  CPU request; same meaning as the loader equivalents.
- CPU_GNT, CPU_RVALID, CPU_Q  out  1/1/DATA_WIDTH  CPU grant, read-valid and read data.
- SRAM_CEN  out  1  SRAM chip enable, active-low.
- SRAM_WEN  out  1  SRAM write enable, active-low.
- SRAM_A  out  ADDR_WIDTH  SRAM address.
- SRAM_D  out  DATA_WIDTH  SRAM write data.
- SRAM_Q  in  DATA_WIDTH  SRAM read data; valid the cycle after the access edge.
- BUSY  out  1  an access or read return is in flight.

Behaviour:
- Reset values (asynchronous, on RST_N low):
  - SRAM_CEN=1, SRAM_WEN=1, SRAM_A=0, SRAM_D=0.
  - LD_GNT=0, CPU_GNT=0, LD_RVALID=0, CPU_RVALID=0, BUSY=0.
  - Hold counter=0. Any pending read is dropped with no RVALID.
- State machine, registered: IDLE, ACC_LD, ACC_CPU. The state at each edge is chosen from the REQ/LOCK/counter values sampled at that edge.
  - Winner loader -> ACC_LD. Winner CPU -> ACC_CPU. No request -> IDLE.
  - Transitions are allowed every cycle, so back-to-back and alternating accesses run at 1 access/cycle.
- In ACC_x:
  - SRAM_CEN=0; SRAM_WEN=!x_WE.
  - SRAM_A and SRAM_D are registered copies of x_A and x_D from the sampling edge.
  - x_GNT=1 for exactly that cycle.
- In IDLE: SRAM_CEN=1, SRAM_WEN=1; SRAM_A and SRAM_D hold their last values.
- Read latency, for a request sampled at edge N:
  - GNT and the SRAM cycle occur in cycle N+1.
  - x_RVALID=1 in cycle N+2 (registered flag); x_Q=SRAM_Q in that cycle.
  - Writes never raise RVALID. x_Q is don't-care when RVALID=0.
- Handshake rules:
  - Requester holds REQ, A, D and WE stable until it sees GNT.
  - In the GNT cycle it either drops REQ or presents its next access; that value is sampled at the end of the GNT cycle.
  - REQ high after GNT is therefore a new access (burst), never a duplicate.
- Arbitration, evaluated at each edge:
  - LOCK=1: the loader wins if requesting; CPU_REQ is ignored; the counter is held at 0.
  - Only one requester: it wins.
  - Both requesting, LOCK=0: the loader wins unless counter==MAX_HOLD, in which case the CPU wins.
- Hold counter (4-bit):
  - +1 on each loader win while CPU_REQ=1 and LOCK=0.
  - Cleared on a CPU win, or on any edge with CPU_REQ=0.
  - Saturates at MAX_HOLD and never wraps.
- LOCK deasserting mid-burst: takes effect at the next sampling edge; the counter restarts from 0.
- BUSY = (state!=IDLE) | LD_RVALID | CPU_RVALID.
- An asynchronous reset asserted during ACC_x aborts the access: CEN returns to 1 immediately, and a write may or may not complete in the SRAM.

Test Plan:
- CPU-only read: CPU_REQ=1, CPU_WE=0, CPU_A=0x010 at edge N.
  - Cycle N+1: CPU_GNT=1, SRAM_CEN=0, SRAM_WEN=1, SRAM_A=0x010.
  - Cycle N+2: CPU_RVALID=1, CPU_Q equals the preloaded 0xA5.
- Loader burst write: LD_A=0x000..0x007 with LD_D=0x30..0x37, advancing on each GNT.
  - Eight consecutive LD_GNT cycles with no bubbles and SRAM_WEN=0.
  - Read-back returns 0x30..0x37.
- Contention, MAX_HOLD=4, LOCK=0, both REQ held continuously (loader bursting):
  - Grant order LD,LD,LD,LD,CPU,LD,LD,LD,LD,CPU.
  - The CPU never waits more than 5 cycles.
- LOCK=1 with both REQ held for 20 cycles:
  - 20 LD_GNT pulses, CPU_GNT=0 throughout.
  - After LOCK drops, the CPU is granted within MAX_HOLD+1 cycles.
- Write then read the same address: CPU writes 0x5C to 0x1FF, then reads 0x1FF back-to-back.
  - CPU_Q=0x5C with CPU_RVALID exactly 2 cycles after the read's sampling edge.
- Reset mid-read: RST_N pulled low in the CPU_GNT cycle of a read.
  - All outputs take reset values immediately; no CPU_RVALID follows.
  - The counter is 0 after release.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester and SRAM-side signal bundle for the SRAM port arbiter
interface sram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic                  lock;

    logic                  ld_req;
    logic                  ld_we;
    logic [ADDR_WIDTH-1:0] ld_a;
    logic [DATA_WIDTH-1:0] ld_d;
    logic                  ld_gnt;
    logic                  ld_rvalid;
    logic [DATA_WIDTH-1:0] ld_q;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_a;
    logic [DATA_WIDTH-1:0] cpu_d;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_q;

    logic                  sram_cen;
    logic                  sram_wen;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;

    logic                  busy;

    // Arbiter side
    modport slave (
        input  lock,
        input  ld_req, ld_we, ld_a, ld_d,
        output ld_gnt, ld_rvalid, ld_q,
        input  cpu_req, cpu_we, cpu_a, cpu_d,
        output cpu_gnt, cpu_rvalid, cpu_q,
        output sram_cen, sram_wen, sram_a, sram_d,
        input  sram_q,
        output busy
    );

    // Requesters plus SRAM macro side
    modport master (
        output lock,
        output ld_req, ld_we, ld_a, ld_d,
        input  ld_gnt, ld_rvalid, ld_q,
        output cpu_req, cpu_we, cpu_a, cpu_d,
        input  cpu_gnt, cpu_rvalid, cpu_q,
        input  sram_cen, sram_wen, sram_a, sram_d,
        output sram_q,
        input  busy
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - registered loader/CPU arbiter for the single-port program/data SRAM
module sram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_HOLD   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_port_arbiter_if.slave   bus
);
    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE,
        ACC_LD,
        ACC_CPU
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            hold_cnt;
    logic [3:0]            hold_cnt_nxt;
    logic [ADDR_WIDTH-1:0] sram_a_q;
    logic [ADDR_WIDTH-1:0] sram_a_nxt;
    logic [DATA_WIDTH-1:0] sram_d_q;
    logic [DATA_WIDTH-1:0] sram_d_nxt;
    logic                  sram_wen_q;
    logic                  sram_wen_nxt;
    logic                  ld_rvalid_q;
    logic                  cpu_rvalid_q;
    logic                  ld_win;
    logic                  cpu_win;

    always_comb begin
        state_nxt    = IDLE;
        sram_wen_nxt = 1'b1;
        sram_a_nxt   = sram_a_q;
        sram_d_nxt   = sram_d_q;
        hold_cnt_nxt = 4'd0;

        // Loader keeps priority until it has been granted MAX_HOLD times over a waiting CPU
        ld_win  = bus.ld_req && (bus.lock || !bus.cpu_req || (hold_cnt != HOLD_MAX));
        cpu_win = bus.cpu_req && !bus.lock && !ld_win;

        if (ld_win) begin
            state_nxt    = ACC_LD;
            sram_wen_nxt = !bus.ld_we;
            sram_a_nxt   = bus.ld_a;
            sram_d_nxt   = bus.ld_d;
        end else if (cpu_win) begin
            state_nxt    = ACC_CPU;
            sram_wen_nxt = !bus.cpu_we;
            sram_a_nxt   = bus.cpu_a;
            sram_d_nxt   = bus.cpu_d;
        end

        // Only a loader win over a waiting, unlocked CPU advances the count; all else clears it
        if (ld_win && bus.cpu_req && !bus.lock) begin
            hold_cnt_nxt = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hold_cnt     <= 4'd0;
            sram_a_q     <= '0;
            sram_d_q     <= '0;
            sram_wen_q   <= 1'b1;
            ld_rvalid_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            sram_a_q     <= sram_a_nxt;
            sram_d_q     <= sram_d_nxt;
            sram_wen_q   <= sram_wen_nxt;
            ld_rvalid_q  <= (state == ACC_LD) && sram_wen_q;
            cpu_rvalid_q <= (state == ACC_CPU) && sram_wen_q;
        end
    end

    assign bus.sram_cen   = (state == IDLE);
    assign bus.sram_wen   = sram_wen_q;
    assign bus.sram_a     = sram_a_q;
    assign bus.sram_d     = sram_d_q;

    assign bus.ld_gnt     = (state == ACC_LD);
    assign bus.cpu_gnt    = (state == ACC_CPU);
    assign bus.ld_rvalid  = ld_rvalid_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    // The macro output is only meaningful in the cycle after a read, which is when RVALID is set
    assign bus.ld_q       = bus.sram_q;
    assign bus.cpu_q      = bus.sram_q;

    assign bus.busy       = (state != IDLE) || ld_rvalid_q || cpu_rvalid_q;
endmodule
